regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register-file write port (a bank of NREG reg16 registers, one enable each)
//  between two writeback requesters: A = ALU writeback, B = load/memory writeback.
//  - Arbitrates per cycle and latches the winning write into a one-entry write stage.
//  - Drives the one-hot register enables and write data from that stage.
//  - Forwards in-flight write data to one read address.
// PARAMETERS
//  DW    16  data width; matches the reg16 width
//  AW    3   register address width
//  NREG  8   number of registers; must equal 2**AW
// PORTS
//  CLK        in   1      clock; all state updates on posedge
//  CLR        in   1      synchronous active-high reset
//  a_req      in   1      A write request; held until a_gnt seen
//  a_addr     in   AW     A destination register
//  a_data     in   DW     A write data
//  b_req      in   1      B write request; held until b_gnt seen
//  b_addr     in   AW     B destination register
//  b_data     in   DW     B write data
//  a_gnt      out  1      combinational; A accepted at the coming edge
//  b_gnt      out  1      combinational; B accepted at the coming edge
//  reg_en     out  NREG   one-hot enable to reg16 En pins; all zero when idle
//  reg_wdata  out  DW     data to all reg16 I pins
//  rd_addr    in   AW     read address checked for forwarding
//  fwd_vld    out  1      stage holds a write to rd_addr
//  fwd_data   out  DW     stage data when fwd_vld=1, else 0
// BEHAVIOUR
//  - State: write stage {wr_vld, wr_addr, wr_data}; round-robin pointer last_b (1 = B granted last).
//  - Reset: CLR=1 at posedge sets wr_vld=0, wr_addr=0, wr_data=0, last_b=1 (A preferred).
//    - While CLR=1: a_gnt=b_gnt=0 combinationally; requests are not accepted.
//    - From the next cycle: reg_en=0, reg_wdata=0, fwd_vld=0, fwd_data=0.
//  - Grant, combinational, at most one per cycle; a_gnt & b_gnt is never 1:
//    - only a_req -> a_gnt; only b_req -> b_gnt; neither -> no grant.
//    - both requesting -> grant A if last_b=1, else B (see CONFIGURATION).
//  - Handshake:
//    - A request is accepted on the edge where its gnt=1.
//    - The requester may change addr/data or drop req in the following cycle.
//    - A held req is re-arbitrated every cycle; the losing request stays pending, no data lost.
//  - Accept edge:
//    - wr_vld<=1, wr_addr/wr_data <= the winner's.
//    - last_b <= (winner==B).
//  - No grant at an edge -> wr_vld<=0; last_b holds.
//  - Outputs (driven from registered stage only, glitch-free):
//    - reg_en = wr_vld ? (1<<wr_addr) : 0.
//    - reg_wdata = wr_vld ? wr_data : 0.
//    - Latency: accepted at edge k; reg_en high in cycle k..k+1; reg16 Q updated at edge k+1.
//    - Back-to-back accepts every cycle are allowed; sustained throughput is 1 write/cycle.
//  - Same-address conflict (a_addr==b_addr, both requesting):
//    - Normal arbitration applies; the loser writes one cycle later.
//    - The loser's value is final.
//  - Forwarding: fwd_vld = wr_vld & (wr_addr==rd_addr); fwd_data = fwd_vld ? wr_data : 0.
//  - Reset mid-operation:
//    - A pending stage write is dropped; reg_en=0 from the CLR edge onward.
//    - Requesters must reissue.
// CONFIGURATION
//  WB_ROUND_ROBIN_EN defined:
//    - On conflict, the winner alternates via last_b.
//    - Worst-case wait for a held request = 1 cycle.
//  WB_ROUND_ROBIN_EN undefined:
//    - Fixed priority: A always beats B; B can starve under continuous A.
//    - last_b is still updated on accept but is ignored for grant selection.
// TESTING
//  1 CLR=1 for 2 cycles with a_req=b_req=1 -> a_gnt=b_gnt=0; after release reg_en=0, fwd_vld=0.
//  2 a_req, a_addr=3, a_data=16'h1234, one cycle -> a_gnt=1; next cycle reg_en=8'h08,
//    reg_wdata=16'h1234; reg3 Q=16'h1234 after the following edge.
//  3 a_req & b_req held, addrs 1/2, data 16'hAAAA/16'h5555 (RR on):
//    - grants A then B on consecutive cycles.
//    - reg_en 8'h02 then 8'h04, no gap.
//  4 Same as 3 with WB_ROUND_ROBIN_EN undefined and A held 4 cycles:
//    - b_gnt=0 for all 4 cycles.
//    - b_gnt=1 in the cycle A drops.
//  5 Both write addr 5 (A=16'h0001, B=16'h0002), RR state A-preferred:
//    - reg5 ends at 16'h0002.
//    - reg_en=8'h20 for 2 consecutive cycles.
//  6 Stage holds addr 6 data 16'hBEEF:
//    - rd_addr=6 -> fwd_vld=1, fwd_data=16'hBEEF.
//    - rd_addr=7 -> fwd_vld=0, fwd_data=0.
//    - CLR mid-write -> reg_en=0 on the next cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto one register-file write port, with forwarding.
// Optional macro WB_ROUND_ROBIN_EN: alternate conflict priority; undefined gives fixed A-over-B.
module regfile_wb_arbiter #(
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 3,
    parameter int unsigned NREG = 8
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            a_req,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_data,
    input  logic            b_req,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_data,
    output logic            a_gnt,
    output logic            b_gnt,
    output logic [NREG-1:0] reg_en,
    output logic [DW-1:0]   reg_wdata,
    input  logic [AW-1:0]   rd_addr,
    output logic            fwd_vld,
    output logic [DW-1:0]   fwd_data
);

    // One-entry write stage and arbitration history
    logic          wr_vld;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          last_b;
    logic          prefer_a;

`ifdef WB_ROUND_ROBIN_EN
    assign prefer_a = last_b;
`else
    // History is still tracked so both builds share identical state behaviour.
    logic unused_last_b;
    assign prefer_a      = 1'b1;
    assign unused_last_b = last_b;
`endif

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!CLR) begin
            unique case ({a_req, b_req})
                2'b10:   a_gnt = 1'b1;
                2'b01:   b_gnt = 1'b1;
                2'b11: begin
                    a_gnt = prefer_a;
                    b_gnt = !prefer_a;
                end
                default: begin
                    a_gnt = 1'b0;
                    b_gnt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            wr_vld  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            last_b  <= 1'b1;
        end else begin
            wr_vld <= a_gnt | b_gnt;
            if (a_gnt) begin
                wr_addr <= a_addr;
                wr_data <= a_data;
            end else if (b_gnt) begin
                wr_addr <= b_addr;
                wr_data <= b_data;
            end
            if (a_gnt || b_gnt) begin
                last_b <= b_gnt;
            end
        end
    end

    // Outputs come straight from the registered stage so the reg16 enables never glitch.
    always_comb begin
        reg_en = '0;
        if (wr_vld) begin
            reg_en[wr_addr] = 1'b1;
        end
    end

    assign reg_wdata = wr_vld ? wr_data : '0;
    assign fwd_vld   = wr_vld && (wr_addr == rd_addr);
    assign fwd_data  = fwd_vld ? wr_data : '0;

    assert property (@(posedge CLK) !(a_gnt && b_gnt));
    assert property (@(posedge CLK) $onehot0(reg_en));
    assert property (@(posedge CLK) CLR |-> !(a_gnt || b_gnt));

endmodule
